// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO.
// Frames are start, LSB-first data, optional parity, then one or two stop bits.
module uart_tx_cfg #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned BAUD_DIVIDER = 434,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_BITS-1:0]               in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic                               tx,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned BAUD_W = $clog2(BAUD_DIVIDER);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_next;
    logic [BAUD_W-1:0]     baud_cnt, baud_next;
    logic [BIT_W-1:0]      bit_cnt, bit_next;
    logic                  stop_cnt, stop_next;
    logic [DATA_BITS-1:0]  shift_q, shift_next;
    logic                  par_q, par_next;
    logic                  tx_next, busy_next, done_next;
    logic                  pop, load, bit_end;

    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [DATA_BITS-1:0]  head;
    logic                  wr_en;

    // Ready is gated by reset so nothing is accepted while it is held.
    assign in_ready = !reset && (fifo_count != CNT_W'(FIFO_DEPTH));
    assign wr_en    = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_cnt  <= bit_next;
            stop_cnt <= stop_next;
            shift_q  <= shift_next;
            par_q    <= par_next;
            tx       <= tx_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

    // Next state and the registered line value for the upcoming cycle.
    always_comb begin
        state_next = state;
        baud_next  = baud_cnt + 1'b1;
        bit_next   = bit_cnt;
        stop_next  = stop_cnt;
        shift_next = shift_q;
        par_next   = par_q;
        tx_next    = tx;
        done_next  = 1'b0;
        load       = 1'b0;
        bit_end    = (baud_cnt == BAUD_W'(BAUD_DIVIDER - 1));

        case (state)
            IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
                if (fifo_count != '0) load = 1'b1;
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                    tx_next    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        if (PARITY_MODE != 0) begin
                            state_next = PARITY;
                            tx_next    = par_q;
                        end else begin
                            state_next = STOP;
                            stop_next  = 1'b0;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        shift_next = shift_q >> 1;
                        bit_next   = bit_cnt + 1'b1;
                        tx_next    = shift_next[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = STOP;
                    stop_next  = 1'b0;
                    tx_next    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        done_next = 1'b1;
                        if (fifo_count != '0) begin
                            load = 1'b1;
                        end else begin
                            state_next = IDLE;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        stop_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Pop the FIFO head straight into the shifter so the start bit follows at once.
        pop = load;
        if (load) begin
            state_next = START;
            baud_next  = '0;
            shift_next = head;
            par_next   = (^head) ^ (PARITY_MODE == 2);
            tx_next    = 1'b0;
        end

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: 8N1, even/odd parity, 5-bit/2-stop, back-to-back and reset abort.
module tb_uart_tx_cfg;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 8N1 instance
    logic [7:0] d_n;  logic v_n = 1'b0; logic r_n, tx_n, b_n, dn_n; logic [2:0] c_n;
    // 8E1 and 8O1 instances
    logic [7:0] d_e;  logic v_e = 1'b0; logic r_e, tx_e, b_e, dn_e; logic [2:0] c_e;
    logic [7:0] d_o;  logic v_o = 1'b0; logic r_o, tx_o, b_o, dn_o; logic [2:0] c_o;
    // 5N2 instance
    logic [4:0] d_5;  logic v_5 = 1'b0; logic r_5, tx_5, b_5, dn_5; logic [2:0] c_5;

    uart_tx_cfg #(.DATA_BITS(8), .BAUD_DIVIDER(4), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n (
        .clk(clk), .reset(reset), .in_data(d_n), .in_valid(v_n), .in_ready(r_n),
        .tx(tx_n), .busy(b_n), .done(dn_n), .fifo_count(c_n));
    uart_tx_cfg #(.DATA_BITS(8), .BAUD_DIVIDER(4), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e (
        .clk(clk), .reset(reset), .in_data(d_e), .in_valid(v_e), .in_ready(r_e),
        .tx(tx_e), .busy(b_e), .done(dn_e), .fifo_count(c_e));
    uart_tx_cfg #(.DATA_BITS(8), .BAUD_DIVIDER(4), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_o (
        .clk(clk), .reset(reset), .in_data(d_o), .in_valid(v_o), .in_ready(r_o),
        .tx(tx_o), .busy(b_o), .done(dn_o), .fifo_count(c_o));
    uart_tx_cfg #(.DATA_BITS(5), .BAUD_DIVIDER(4), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_5 (
        .clk(clk), .reset(reset), .in_data(d_5), .in_valid(v_5), .in_ready(r_5),
        .tx(tx_5), .busy(b_5), .done(dn_5), .fifo_count(c_5));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (tx_n !== 1'b1)   begin n_fail++; $display("FAIL reset_tx got %b want 1", tx_n); end
        n_checks++; if (b_n !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b want 0", b_n); end
        n_checks++; if (dn_n !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", dn_n); end
        n_checks++; if (c_n !== 3'd0)    begin n_fail++; $display("FAIL reset_count got %0d want 0", c_n); end
        n_checks++; if (r_n !== 1'b0)    begin n_fail++; $display("FAIL reset_ready got %b want 0", r_n); end
        n_checks++; if (tx_5 !== 1'b1)   begin n_fail++; $display("FAIL reset_tx5 got %b want 1", tx_5); end
        reset = 1'b0;
        #1;
        n_checks++; if (r_n !== 1'b1)    begin n_fail++; $display("FAIL ready_after_reset got %b want 1", r_n); end
        tick(); tick();
    endtask

    task automatic test_frame_8n1;
        logic [9:0] exp_bits;
        logic       exp_tx;
        int         ndone;
        exp_bits = 10'b1101001010;
        ndone = 0;
        v_n = 1'b1; d_n = 8'hA5;
        for (int c = 1; c <= 46; c++) begin
            tick();
            v_n = 1'b0;
            exp_tx = (c >= 2 && c <= 41) ? exp_bits[(c - 2) / 4] : 1'b1;
            if (dn_n === 1'b1) ndone++;
            n_checks++; if (tx_n !== exp_tx) begin n_fail++; $display("FAIL 8n1_tx cycle %0d got %b want %b", c, tx_n, exp_tx); end
            n_checks++; if (b_n !== (c >= 2 && c <= 41)) begin n_fail++; $display("FAIL 8n1_busy cycle %0d got %b", c, b_n); end
            n_checks++; if (dn_n !== (c == 42)) begin n_fail++; $display("FAIL 8n1_done cycle %0d got %b", c, dn_n); end
            if (c == 1) begin
                n_checks++; if (c_n !== 3'd1) begin n_fail++; $display("FAIL 8n1_count_c1 got %0d want 1", c_n); end
            end
            if (c == 2) begin
                n_checks++; if (c_n !== 3'd0) begin n_fail++; $display("FAIL 8n1_count_c2 got %0d want 0", c_n); end
            end
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL 8n1_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_parity;
        logic [10:0] exp_e, exp_o;
        logic        te, to;
        exp_e = 11'b11000001110;
        exp_o = 11'b10000001110;
        v_e = 1'b1; d_e = 8'h07;
        v_o = 1'b1; d_o = 8'h07;
        for (int c = 1; c <= 48; c++) begin
            tick();
            v_e = 1'b0; v_o = 1'b0;
            te = (c >= 2 && c <= 45) ? exp_e[(c - 2) / 4] : 1'b1;
            to = (c >= 2 && c <= 45) ? exp_o[(c - 2) / 4] : 1'b1;
            n_checks++; if (tx_e !== te) begin n_fail++; $display("FAIL even_tx cycle %0d got %b want %b", c, tx_e, te); end
            n_checks++; if (tx_o !== to) begin n_fail++; $display("FAIL odd_tx cycle %0d got %b want %b", c, tx_o, to); end
            n_checks++; if (dn_e !== (c == 46)) begin n_fail++; $display("FAIL even_done cycle %0d got %b", c, dn_e); end
            n_checks++; if (b_o !== (c >= 2 && c <= 45)) begin n_fail++; $display("FAIL odd_busy cycle %0d got %b", c, b_o); end
        end
    endtask

    task automatic test_5n2;
        logic [7:0] exp_bits;
        logic       exp_tx;
        exp_bits = 8'b11111110;
        v_5 = 1'b1; d_5 = 5'h1F;
        for (int c = 1; c <= 36; c++) begin
            tick();
            v_5 = 1'b0;
            exp_tx = (c >= 2 && c <= 33) ? exp_bits[(c - 2) / 4] : 1'b1;
            n_checks++; if (tx_5 !== exp_tx) begin n_fail++; $display("FAIL 5n2_tx cycle %0d got %b want %b", c, tx_5, exp_tx); end
            n_checks++; if (dn_5 !== (c == 34)) begin n_fail++; $display("FAIL 5n2_done cycle %0d got %b", c, dn_5); end
            n_checks++; if (b_5 !== (c >= 2 && c <= 33)) begin n_fail++; $display("FAIL 5n2_busy cycle %0d got %b", c, b_5); end
        end
    endtask

    task automatic test_back_to_back;
        logic       sent16;
        logic [9:0] f;
        logic [7:0] w;
        logic       exp_tx;
        int         k, ndone;
        sent16 = 1'b0;
        ndone = 0;
        for (int c = 0; c <= 245; c++) begin
            if (c > 0) tick();
            if (c >= 2 && c <= 241) begin
                k = (c - 2) / 40;
                w = 8'h11 + 8'(k);
                f = {1'b1, w, 1'b0};
                exp_tx = f[((c - 2) % 40) / 4];
            end else begin
                exp_tx = 1'b1;
            end
            if (dn_n === 1'b1) ndone++;
            n_checks++; if (tx_n !== exp_tx) begin n_fail++; $display("FAIL b2b_tx cycle %0d got %b want %b", c, tx_n, exp_tx); end
            n_checks++; if (b_n !== (c >= 2 && c <= 241)) begin n_fail++; $display("FAIL b2b_busy cycle %0d got %b", c, b_n); end
            n_checks++; if (dn_n !== (c >= 42 && c <= 242 && (c - 42) % 40 == 0)) begin n_fail++; $display("FAIL b2b_done cycle %0d got %b", c, dn_n); end
            if (c <= 42) begin
                n_checks++; if (r_n !== (c <= 4 || c == 42)) begin n_fail++; $display("FAIL b2b_ready cycle %0d got %b", c, r_n); end
            end
            if (c == 5) begin
                n_checks++; if (c_n !== 3'd4) begin n_fail++; $display("FAIL b2b_count_full got %0d want 4", c_n); end
            end
            if (c == 43) begin
                n_checks++; if (c_n !== 3'd4) begin n_fail++; $display("FAIL b2b_count_c43 got %0d want 4", c_n); end
            end
            if (c < 5) begin
                v_n = 1'b1; d_n = 8'h11 + 8'(c);
            end else if (sent16) begin
                v_n = 1'b0;
            end else begin
                v_n = 1'b1; d_n = 8'h16;
                if (r_n === 1'b1) sent16 = 1'b1;
            end
        end
        v_n = 1'b0;
        n_checks++; if (ndone != 6) begin n_fail++; $display("FAIL b2b_done_count got %0d want 6", ndone); end
    endtask

    task automatic test_reset_mid_frame;
        v_n = 1'b1; d_n = 8'h3C;
        tick(); d_n = 8'h5A;
        tick(); d_n = 8'h66;
        tick(); v_n = 1'b0;
        for (int c = 3; c < 22; c++) tick();
        n_checks++; if (c_n !== 3'd2) begin n_fail++; $display("FAIL mid_count_before got %0d want 2", c_n); end
        n_checks++; if (b_n !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", b_n); end
        reset = 1'b1;
        tick();
        n_checks++; if (tx_n !== 1'b1) begin n_fail++; $display("FAIL mid_tx got %b want 1", tx_n); end
        n_checks++; if (b_n !== 1'b0)  begin n_fail++; $display("FAIL mid_busy got %b want 0", b_n); end
        n_checks++; if (c_n !== 3'd0)  begin n_fail++; $display("FAIL mid_count got %0d want 0", c_n); end
        n_checks++; if (dn_n !== 1'b0) begin n_fail++; $display("FAIL mid_done got %b want 0", dn_n); end
        n_checks++; if (r_n !== 1'b0)  begin n_fail++; $display("FAIL mid_ready got %b want 0", r_n); end
        reset = 1'b0;
        #1;
        n_checks++; if (r_n !== 1'b1)  begin n_fail++; $display("FAIL mid_ready_after got %b want 1", r_n); end
        for (int c = 0; c < 60; c++) begin
            tick();
            n_checks++;
            if (tx_n !== 1'b1 || b_n !== 1'b0 || dn_n !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_quiet cycle %0d got tx=%b busy=%b done=%b want 1/0/0", c, tx_n, b_n, dn_n);
            end
        end
    endtask

    initial begin
        d_n = '0; d_e = '0; d_o = '0; d_5 = '0;
        test_reset();
        test_frame_8n1();
        tick(); tick();
        test_parity();
        tick(); tick();
        test_5n2();
        tick(); tick();
        test_back_to_back();
        tick(); tick();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
